// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage between ex_mem and mem_wb.
// Runs load/store transactions on a req/ack data bus, steers byte lanes,
// sign/zero-extends loads, flags misaligned accesses and bus timeouts, and
// holds the pipeline through stallreq_o while a bus cycle is outstanding.
module mem_access #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        flush_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic [1:0]  excp_o
);
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    // Last counter value in WAIT/DRAIN before the access is abandoned.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN, DONE} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [31:0] data_q;
    logic        to_q;

    logic        is_load, is_store, is_mem, misalign;
    logic [3:0]  be_c;
    logic [31:0] st_data, ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign is_mem = is_load | is_store;

    // Decode the op: access class, alignment check, store lane steering.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        misalign = 1'b0;
        be_c     = 4'b1111;
        st_data  = 32'h0;
        case (aluop_i)
            EXE_LB_OP, EXE_LBU_OP: is_load = 1'b1;
            EXE_LH_OP, EXE_LHU_OP: begin
                is_load  = 1'b1;
                misalign = mem_addr_i[0];
            end
            EXE_LW_OP: begin
                is_load  = 1'b1;
                misalign = |mem_addr_i[1:0];
            end
            EXE_SB_OP: begin
                is_store = 1'b1;
                be_c     = 4'b0001 << mem_addr_i[1:0];
                st_data  = {4{reg2_i[7:0]}};
            end
            EXE_SH_OP: begin
                is_store = 1'b1;
                misalign = mem_addr_i[0];
                be_c     = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                st_data  = {2{reg2_i[15:0]}};
            end
            EXE_SW_OP: begin
                is_store = 1'b1;
                misalign = |mem_addr_i[1:0];
                st_data  = reg2_i;
            end
            default: ;
        endcase
    end

    // Pick the addressed byte/half out of the returned word and extend it.
    always_comb begin
        case (mem_addr_i[1:0])
            2'd0:    ld_byte = dbus_rdata[7:0];
            2'd1:    ld_byte = dbus_rdata[15:8];
            2'd2:    ld_byte = dbus_rdata[23:16];
            default: ld_byte = dbus_rdata[31:24];
        endcase
        ld_half = mem_addr_i[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        case (aluop_i)
            EXE_LB_OP:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            EXE_LBU_OP: ld_data = {24'h0, ld_byte};
            EXE_LH_OP:  ld_data = {{16{ld_half[15]}}, ld_half};
            EXE_LHU_OP: ld_data = {16'h0, ld_half};
            default:    ld_data = dbus_rdata;
        endcase
    end

    // Bus-cycle FSM: timeout counter, load-data latch and timeout flag.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state  <= IDLE;
            cnt    <= 8'h0;
            data_q <= 32'h0;
            to_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!flush_i && is_mem && !misalign) begin
                        cnt  <= 8'h0;
                        to_q <= 1'b0;
                        if (dbus_ack) begin
                            data_q <= ld_data;
                            state  <= DONE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dbus_ack) begin
                        // A flush arriving with the ack still drops the data.
                        if (flush_i) begin
                            state <= IDLE;
                        end else begin
                            data_q <= ld_data;
                            state  <= DONE;
                        end
                    end else if (flush_i) begin
                        cnt   <= 8'h0;
                        state <= DRAIN;
                    end else if (cnt == TO_LAST) begin
                        to_q  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DRAIN: begin
                    if (dbus_ack || cnt == TO_LAST) state <= IDLE;
                    else                             cnt   <= cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage outputs and bus drive; everything is held at zero during reset.
    always_comb begin
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = wdata_i;
        excp_o     = 2'b00;
        stallreq_o = 1'b0;
        dbus_req   = 1'b0;
        case (state)
            IDLE: begin
                if (flush_i) begin
                    wd_o    = 5'h0;
                    wreg_o  = 1'b0;
                    wdata_o = 32'h0;
                end else if (is_mem) begin
                    wreg_o = 1'b0;
                    if (misalign) begin
                        excp_o = is_load ? 2'b01 : 2'b10;
                    end else begin
                        dbus_req   = 1'b1;
                        stallreq_o = 1'b1;
                    end
                end
            end
            WAIT, DRAIN: begin
                wreg_o     = 1'b0;
                dbus_req   = 1'b1;
                stallreq_o = 1'b1;
            end
            default: begin
                if (flush_i) begin
                    wd_o    = 5'h0;
                    wreg_o  = 1'b0;
                    wdata_o = 32'h0;
                end else begin
                    wreg_o  = wreg_i & is_load & ~to_q;
                    wdata_o = is_load ? data_q : wdata_i;
                    excp_o  = to_q ? 2'b11 : 2'b00;
                end
            end
        endcase
        dbus_we    = dbus_req & is_store;
        dbus_addr  = dbus_req ? {mem_addr_i[31:2], 2'b00} : 32'h0;
        dbus_be    = dbus_req ? be_c : 4'h0;
        dbus_wdata = dbus_req ? st_data : 32'h0;
        if (!clr_n) begin
            wd_o       = 5'h0;
            wreg_o     = 1'b0;
            wdata_o    = 32'h0;
            excp_o     = 2'b00;
            stallreq_o = 1'b0;
            dbus_req   = 1'b0;
            dbus_we    = 1'b0;
            dbus_addr  = 32'h0;
            dbus_be    = 4'h0;
            dbus_wdata = 32'h0;
        end
    end
endmodule
